read_level_ctrl: RTL and testbench



---
 rtl/read_level_ctrl_pkg.sv | 25 ++
 rtl/read_level_ctrl_window.sv | 56 +++++
 rtl/read_level_ctrl.sv | 148 ++++++++++++++
 tb/tb_read_level_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/read_level_ctrl_pkg.sv
// Shared types for the read-leveling sequencer: FSM states and the window record.
package read_level_ctrl_pkg;

  // Width of the tap fields in the window record; DLY_WIDTH must equal this.
  localparam int TAP_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_APPLY,
    S_APPLY_SETTLE,
    S_FIN
  } state_t;

  typedef struct packed {
    logic [TAP_W-1:0] lo;
    logic [TAP_W-1:0] hi;
    logic             inv;
    logic [TAP_W:0]   len;
  } win_t;

endpackage

// File: rtl/read_level_ctrl_window.sv
// Run/best-window tracker: opens, extends and closes passing runs per sweep point
// and keeps the longest run seen (earliest wins ties).
module read_level_window
  import read_level_ctrl_pkg::*;
#(
  parameter int DLY_WIDTH = TAP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 eval,
  input  logic                 pass,
  input  logic                 inv,
  input  logic [DLY_WIDTH-1:0] tap,
  output win_t                 best
);

  logic                 run_open;
  logic [DLY_WIDTH-1:0] run_lo;
  logic                 last;
  logic                 close;
  logic [DLY_WIDTH-1:0] lo_cur;
  logic [DLY_WIDTH-1:0] c_hi;
  logic [DLY_WIDTH:0]   c_len;

  always_comb begin
    last   = (tap == '1);
    lo_cur = run_open ? run_lo : tap;
    // A failing point ends the run one tap earlier; the top tap always ends it.
    close  = (pass && last) || (!pass && run_open);
    c_hi   = pass ? tap : tap - 1'b1;
    c_len  = {1'b0, c_hi} - {1'b0, lo_cur} + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      run_open <= 1'b0;
      run_lo   <= '0;
      best     <= '0;
    end else if (eval) begin
      if (pass && !last) begin
        run_open <= 1'b1;
        run_lo   <= lo_cur;
      end else begin
        run_open <= 1'b0;
      end
      if (close && (c_len > best.len)) begin
        best.lo  <= lo_cur;
        best.hi  <= c_hi;
        best.inv <= inv;
        best.len <= c_len;
      end
    end
  end

endmodule

// File: rtl/read_level_ctrl.sv
// Read-leveling sequencer for one DQ/DQS lane: sweeps idelay tap and clkdiv
// inversion, scores each point against a training nibble, programs window centre.
module read_level_ctrl
  import read_level_ctrl_pkg::*;
#(
  parameter int DLY_WIDTH     = TAP_W,
  parameter int NUM_SAMPLES   = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           pattern,
  input  logic [3:0]           dout,
  output logic                 dly_ld,
  output logic [DLY_WIDTH-1:0] dly_val,
  output logic                 inv_clk_div,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [DLY_WIDTH-1:0] win_lo,
  output logic [DLY_WIDTH-1:0] win_hi,
  output logic                 win_inv
);

  localparam int CNT_MAX = (NUM_SAMPLES > SETTLE_CYCLES) ? NUM_SAMPLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(NUM_SAMPLES - 1);

  state_t               state;
  logic [DLY_WIDTH-1:0] tap;
  logic                 inv;
  logic                 pass;
  logic [CNT_W-1:0]     cnt;
  win_t                 best;
  logic                 clr;
  logic                 eval;
  logic [DLY_WIDTH:0]   sum;

  assign clr  = (state == S_IDLE) && start;
  assign eval = (state == S_EVAL);
  assign sum  = {1'b0, best.lo} + {1'b0, best.hi};

  read_level_window #(.DLY_WIDTH(DLY_WIDTH)) u_window (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .eval (eval),
    .pass (pass),
    .inv  (inv),
    .tap  (tap),
    .best (best)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tap         <= '0;
      inv         <= 1'b0;
      pass        <= 1'b0;
      cnt         <= '0;
      dly_ld      <= 1'b0;
      dly_val     <= '0;
      inv_clk_div <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      win_lo      <= '0;
      win_hi      <= '0;
      win_inv     <= 1'b0;
    end else begin
      dly_ld <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          done  <= 1'b0;
          fail  <= 1'b0;
          busy  <= 1'b1;
          tap   <= '0;
          inv   <= 1'b0;
          state <= S_LOAD;
        end
        S_LOAD: begin
          dly_val     <= tap;
          inv_clk_div <= inv;
          dly_ld      <= 1'b1;
          cnt         <= '0;
          state       <= S_SETTLE;
        end
        S_SETTLE: if (cnt == SET_LAST) begin
          cnt   <= '0;
          pass  <= 1'b1;
          state <= S_SAMPLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_SAMPLE: begin
          if (dout != pattern) pass <= 1'b0;
          if (cnt == SMP_LAST) begin
            cnt   <= '0;
            state <= S_EVAL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EVAL: if (tap != '1) begin
          tap   <= tap + 1'b1;
          state <= S_LOAD;
        end else if (!inv) begin
          inv   <= 1'b1;
          tap   <= '0;
          state <= S_LOAD;
        end else begin
          state <= S_APPLY;
        end
        S_APPLY: begin
          dly_ld <= 1'b1;
          cnt    <= '0;
          state  <= S_APPLY_SETTLE;
          if (best.len != '0) begin
            dly_val     <= sum[DLY_WIDTH:1];
            inv_clk_div <= best.inv;
            win_lo      <= best.lo;
            win_hi      <= best.hi;
            win_inv     <= best.inv;
            fail        <= 1'b0;
          end else begin
            dly_val     <= '0;
            inv_clk_div <= 1'b0;
            win_lo      <= '0;
            win_hi      <= '0;
            win_inv     <= 1'b0;
            fail        <= 1'b1;
          end
        end
        S_APPLY_SETTLE: if (cnt == SET_LAST) state <= S_FIN;
                        else cnt <= cnt + 1'b1;
        S_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_level_ctrl.sv
// Bench for read_level_ctrl: lane model drives dout from the programmed tap/inversion,
// a table of directed sweeps plus randomized pass maps scored by a run-length model.
module tb_read_level_ctrl;

  localparam int SETTLE = 8;
  localparam int NSMP   = 16;
  localparam int LAT    = 2 * 32 * (SETTLE + NSMP + 2) + SETTLE + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pattern = 4'h0;
  logic [3:0] dout = 4'h0;
  logic       dly_ld;
  logic [4:0] dly_val;
  logic       inv_clk_div;
  logic       busy;
  logic       done;
  logic       fail;
  logic [4:0] win_lo;
  logic [4:0] win_hi;
  logic       win_inv;

  read_level_ctrl #(.DLY_WIDTH(5), .NUM_SAMPLES(NSMP), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .dout(dout),
    .dly_ld(dly_ld), .dly_val(dly_val), .inv_clk_div(inv_clk_div),
    .busy(busy), .done(done), .fail(fail),
    .win_lo(win_lo), .win_hi(win_hi), .win_inv(win_inv)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Lane model: pass map per inversion, plus one optional bad nibble at (inv0, gtap, sample gsamp).
  logic [31:0] mask0 = '0;
  logic [31:0] mask1 = '0;
  int gtap = -1;
  int gsamp = 0;
  int since_ld = 0;

  always @(negedge clk) begin
    if (dly_ld) since_ld = 1;
    else since_ld++;
    if ((inv_clk_div ? mask1[dly_val] : mask0[dly_val]) &&
        !(!inv_clk_div && gtap == int'(dly_val) && since_ld == SETTLE + 1 + gsamp))
      dout = pattern;
    else
      dout = ~pattern;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Longest contiguous passing run over inv=0 then inv=1; strict improvement only.
  task automatic model(input logic [31:0] m0, input logic [31:0] m1, input int gt,
                       output logic [4:0] lo, output logic [4:0] hi, output logic iv,
                       output logic [4:0] dv, output logic f);
    int best = 0, blo = 0, bhi = 0, binv = 0, run;
    logic [31:0] m;
    for (int v = 0; v < 2; v++) begin
      m = v ? m1 : m0;
      if (v == 0 && gt >= 0) m[gt] = 1'b0;
      run = 0;
      for (int t = 0; t <= 32; t++) begin
        if (t < 32 && m[t]) run++;
        else begin
          if (run > best) begin best = run; blo = t - run; bhi = t - 1; binv = v; end
          run = 0;
        end
      end
    end
    f  = (best == 0);
    lo = 5'(blo);
    hi = 5'(bhi);
    iv = (binv != 0);
    dv = 5'((blo + bhi) / 2);
  endtask

  task automatic run_sweep(input string tag, input logic [31:0] m0, input logic [31:0] m1,
                           input logic [3:0] pat, input int gt, input int gs,
                           input logic [4:0] elo, input logic [4:0] ehi, input logic einv,
                           input logic [4:0] edv, input logic efail, input int restart_at);
    int lat = 0, lds = 0;
    mask0 = m0; mask1 = m1; pattern = pat; gtap = gt; gsamp = gs;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, " busy"}, busy, 1);
    while (!done && lat < 4000) begin
      @(negedge clk);
      lat++;
      if (dly_ld) lds++;
      start = (lat == restart_at);
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, LAT);
    chk({tag, " busy_end"}, busy, 0);
    chk({tag, " fail"}, fail, efail);
    chk({tag, " win_lo"}, win_lo, elo);
    chk({tag, " win_hi"}, win_hi, ehi);
    chk({tag, " win_inv"}, win_inv, einv);
    chk({tag, " dly_val"}, dly_val, edv);
    chk({tag, " inv_clk_div"}, inv_clk_div, einv);
    chk({tag, " dly_ld_count"}, lds, 65);
  endtask

  typedef struct {
    logic [31:0] m0, m1;
    logic [3:0]  pat;
    int          gt, gs;
    logic [4:0]  lo, hi;
    logic        inv;
    logic [4:0]  dv;
    logic        f;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] r0, r1;
    logic [4:0]  elo, ehi, edv;
    logic        einv, ef;
    int          gt;

    tbl[0] = '{rng(10, 20), 32'h0, 4'b0101, -1, 0, 5'd10, 5'd20, 1'b0, 5'd15, 1'b0};
    tbl[1] = '{rng(10, 13), rng(20, 23), 4'b0011, -1, 0, 5'd10, 5'd13, 1'b0, 5'd11, 1'b0};
    tbl[2] = '{rng(10, 13), rng(20, 24), 4'b1100, -1, 0, 5'd20, 5'd24, 1'b1, 5'd22, 1'b0};
    tbl[3] = '{rng(2, 4) | rng(8, 15), 32'h0, 4'b0110, 12, 9, 5'd8, 5'd11, 1'b0, 5'd9, 1'b0};
    tbl[4] = '{rng(25, 31), 32'h0, 4'b1001, -1, 0, 5'd25, 5'd31, 1'b0, 5'd28, 1'b0};
    tbl[5] = '{32'h0, 32'h0, 4'b1010, -1, 0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst dly_ld", dly_ld, 0);
    chk("rst dly_val", dly_val, 0);
    chk("rst inv_clk_div", inv_clk_div, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst fail", fail, 0);
    chk("rst win_lo", win_lo, 0);
    chk("rst win_hi", win_hi, 0);
    chk("rst win_inv", win_inv, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_sweep($sformatf("vec%0d", i), tbl[i].m0, tbl[i].m1, tbl[i].pat, tbl[i].gt, tbl[i].gs,
                tbl[i].lo, tbl[i].hi, tbl[i].inv, tbl[i].dv, tbl[i].f, -1);

    // Reset in the middle of a sweep, with a coincident start that must lose.
    mask0 = rng(3, 9); mask1 = 32'h0; pattern = 4'h5; gtap = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (499) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst dly_val", dly_val, 0);
    chk("midrst dly_ld", dly_ld, 0);
    chk("midrst inv_clk_div", inv_clk_div, 0);
    chk("midrst done", done, 0);
    start = 1'b0;
    @(negedge clk);
    chk("rst_vs_start busy", busy, 0);
    rst = 1'b0;
    run_sweep("after_rst", rng(3, 9), 32'h0, 4'h5, -1, 0, 5'd3, 5'd9, 1'b0, 5'd6, 1'b0, 100);

    for (int r = 0; r < 8; r++) begin
      case (r % 3)
        0: begin r0 = $urandom() & $urandom(); r1 = $urandom() & $urandom() & $urandom(); end
        1: begin
          r0 = rng($urandom_range(0, 15), $urandom_range(15, 31));
          r1 = rng($urandom_range(0, 20), $urandom_range(20, 31));
        end
        default: begin r0 = $urandom(); r1 = $urandom(); end
      endcase
      gt = $urandom_range(0, 1) ? int'($urandom_range(0, 31)) : -1;
      model(r0, r1, gt, elo, ehi, einv, edv, ef);
      run_sweep($sformatf("rand%0d", r), r0, r1, 4'($urandom_range(0, 15)), gt,
                int'($urandom_range(0, NSMP - 1)), elo, ehi, einv, edv, ef, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
